rr_arb_4_stage: RTL and testbench

Registered 4-source round-robin arbitration stage that feeds the 4:1 data-selection path. It takes four independent valid/ready sources of WIDTH-bit data, picks one per cycle fairly, and presents the winner on a single registered output. The output carries the winning index `out_src` as a 2-bit select, matching the 4:1 mux select encoding: 0→d0, 1→d1, 2→d2, 3→d3. Full throughput: one transfer per cycle when downstream is ready.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick_4.sv | 56 +++++
 rtl/rr_arb_4_stage.sv | 101 ++++++++++
 tb/tb_rr_arb_4_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared sizes and types for the 4-source round-robin arbiter
// Purpose: source count, index width and the index/vector types used by the
//          picker and the arbitration stage. No ports.
package arb_pkg;

  localparam int N_SRC = 4;
  localparam int SRC_W = 2;

  typedef logic [SRC_W-1:0] src_idx_t;
  typedef logic [N_SRC-1:0] src_vec_t;

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - combinational 4-way round-robin picker
// Purpose: choose the first requester at or after ptr (mod 4).
// Ports:
//   req    - request vector, bit i = source i
//   ptr    - highest-priority source index
//   any    - at least one request present
//   idx    - winning source index (0 when no request)
//   onehot - one-hot of the winner (all zero when no request)
module rr_pick_4
  import arb_pkg::*;
(
  input  src_vec_t req,
  input  src_idx_t ptr,
  output logic     any,
  output src_idx_t idx,
  output src_vec_t onehot
);

  logic [2*N_SRC-1:0] req_dbl;
  src_vec_t           req_rot;
  src_vec_t           oh_rot;
  src_idx_t           off;
  logic [2*N_SRC-1:0] oh_dbl;

  // Rotate so that the pointer source lands at bit 0: req_rot[i] = req[(ptr+i)%4].
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_SRC];

  // Fixed priority on the rotated vector, lowest bit wins.
  always_comb begin
    off    = '0;
    oh_rot = '0;
    if (req_rot[0]) begin
      off    = 2'd0;
      oh_rot = 4'b0001;
    end else if (req_rot[1]) begin
      off    = 2'd1;
      oh_rot = 4'b0010;
    end else if (req_rot[2]) begin
      off    = 2'd2;
      oh_rot = 4'b0100;
    end else if (req_rot[3]) begin
      off    = 2'd3;
      oh_rot = 4'b1000;
    end
  end

  // Rotate the one-hot back; the upper half of the doubled, shifted vector
  // holds the wrapped result.
  assign oh_dbl = {oh_rot, oh_rot} << ptr;
  assign onehot = oh_dbl[2*N_SRC-1:N_SRC];

  assign any = |req;
  assign idx = any ? src_idx_t'(ptr + off) : '0;

endmodule

// File: rtl/rr_arb_4_stage.sv
// rtl/rr_arb_4_stage.sv - registered 4-source round-robin arbitration stage
// Purpose: fairly picks one of four valid/ready sources per cycle and holds
//          the winner in a single output register with full throughput.
// Ports:
//   clk, rst_n            - clock (rising edge), async active-low reset
//   in_valid[3:0]         - per-source valid
//   in_data0..in_data3    - per-source payloads
//   in_ready[3:0]         - per-source accept, at most one bit high
//   out_valid/out_data    - registered winning item
//   out_src               - registered winner index (4:1 mux select)
//   out_ready             - downstream accept
module rr_arb_4_stage
  import arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  src_idx_t         out_src_q,   out_src_d;
  src_idx_t         ptr_q,       ptr_d;

  logic             any;
  src_idx_t         g;
  src_vec_t         g_onehot;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  rr_pick_4 u_pick (
    .req    (in_valid),
    .ptr    (ptr_q),
    .any    (any),
    .idx    (g),
    .onehot (g_onehot)
  );

  // Loading while the current item drains keeps one transfer per cycle
  // without a skid buffer.
  assign can_load = !out_valid_q || out_ready;
  assign load     = can_load && any;
  assign in_ready = load ? g_onehot : 4'b0000;

  // Payload only reaches the register, never the ready path.
  always_comb begin
    sel_data = in_data0;
    case (g)
      2'd0:    sel_data = in_data0;
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      default: sel_data = in_data3;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = g;
      ptr_d       = src_idx_t'(g + 2'd1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_arb_4_stage.sv
// tb/tb_rr_arb_4_stage.sv - self-checking bench for rr_arb_4_stage
module tb_rr_arb_4_stage;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  rr_arb_4_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       v;
    logic             ordy;
    logic [3:0]       exp_ir;
    logic             exp_ov;
    logic [1:0]       exp_src;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t tab [21];

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb_data [$];
  logic [1:0]       sb_src  [$];
  logic             m_valid;
  logic [1:0]       m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 2'd0;
    sb_data.delete();
    sb_src.delete();
  endtask

  // One clock cycle: drive, check combinational ready against the model,
  // update the scoreboard, clock, then check the registered output.
  task automatic step(input logic [3:0] v, input logic ordy,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] e,
                      output logic [3:0] ir_seen);
    logic [WIDTH-1:0] dd [4];
    logic [1:0]       g;
    logic [1:0]       idx;
    logic             any;
    logic             load;
    logic [3:0]       exp_ir;
    in_valid  = v;
    out_ready = ordy;
    in_data0  = a; in_data1 = b; in_data2 = c; in_data3 = e;
    dd[0] = a; dd[1] = b; dd[2] = c; dd[3] = e;
    #1;
    any = 1'b0;
    g   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = m_ptr + 2'(k);
      if (!any && v[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
    load   = (!m_valid || ordy) && any;
    exp_ir = load ? (4'b0001 << g) : 4'b0000;
    ir_seen = in_ready;
    chk("in_ready", {28'd0, in_ready}, {28'd0, exp_ir});
    if (m_valid && ordy && sb_data.size() > 0) begin
      void'(sb_data.pop_front());
      void'(sb_src.pop_front());
    end
    if (load) begin
      sb_data.push_back(dd[g]);
      sb_src.push_back(g);
    end
    @(posedge clk);
    #1;
    m_valid = load || (m_valid && !ordy);
    if (load) m_ptr = g + 2'd1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      if (sb_data.size() > 0) begin
        chk("sb_out_data", {28'd0, out_data}, {28'd0, sb_data[0]});
        chk("sb_out_src", {30'd0, out_src}, {30'd0, sb_src[0]});
      end else begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end
    end
  endtask

  logic [3:0] ir;

  initial begin
    //           v        ordy  exp_ir   ov    src   data
    tab[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
    tab[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
    tab[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
    tab[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
    tab[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
    tab[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA};
    tab[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA};
    tab[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA};
    tab[8]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
    tab[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'hB};
    tab[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'hB};
    tab[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
    tab[12] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
    tab[13] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
    tab[14] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
    tab[15] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
    tab[16] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA};
    tab[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'hA};
    tab[18] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1, 4'hB};
    tab[19] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd1, 4'hB};
    tab[20] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};

    // Reset with every source requesting.
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data0 = 4'hA; in_data1 = 4'hB; in_data2 = 4'hC; in_data3 = 4'hD;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {28'd0, out_data}, 32'd0);
    chk("rst_out_src", {30'd0, out_src}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'h1);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(tab[i].v, tab[i].ordy, 4'hA, 4'hB, 4'hC, 4'hD, ir);
      chk($sformatf("tab%0d_in_ready", i), {28'd0, ir}, {28'd0, tab[i].exp_ir});
      chk($sformatf("tab%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tab[i].exp_ov});
      chk($sformatf("tab%0d_out_src", i), {30'd0, out_src}, {30'd0, tab[i].exp_src});
      chk($sformatf("tab%0d_out_data", i), {28'd0, out_data}, {28'd0, tab[i].exp_data});
    end

    // Asynchronous reset between edges while an item is held.
    step(4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, ir);
    chk("pre_areset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_out_data", {28'd0, out_data}, 32'd0);
    chk("areset_out_src", {30'd0, out_src}, 32'd0);
    chk("areset_in_ready", {28'd0, in_ready}, 32'h1);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Sparse request from ptr=0, then wrap from ptr=3.
    step(4'b0100, 1'b1, 4'h5, 4'h6, 4'h7, 4'h8, ir);
    chk("sparse_ir", {28'd0, ir}, 32'h4);
    chk("sparse_src", {30'd0, out_src}, 32'd2);
    chk("sparse_data", {28'd0, out_data}, 32'h7);
    step(4'b0011, 1'b1, 4'h5, 4'h6, 4'h7, 4'h8, ir);
    chk("wrap_ir", {28'd0, ir}, 32'h1);
    chk("wrap_src", {30'd0, out_src}, 32'd0);
    chk("wrap_data", {28'd0, out_data}, 32'h5);
    step(4'b0011, 1'b1, 4'h5, 4'h6, 4'h7, 4'h8, ir);
    chk("wrap_next_src", {30'd0, out_src}, 32'd1);

    // Random traffic against the model and scoreboard.
    for (int n = 0; n < 300; n++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), ir);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
